// File: rtl/div16_seq.sv
`default_nettype none
// ============================================================================
// Module  : div16_seq
// Brief   : 16-bit sequential restoring divider, signed/unsigned, fixed latency
// Revision: 1.0
// ============================================================================
module div16_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        Start,
    input  logic        Signed,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [15:0] Quot,
    output logic [15:0] Rem,
    output logic        Busy,
    output logic        Done,
    output logic        DivZero,
    output logic        OFs
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALC = 2'd1;
    localparam logic [1:0] c_FIX  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic [3:0]  r_cnt;
    logic        r_fix;
    logic        r_sgn;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [16:0] r_bmag;
    logic [15:0] r_q;
    logic [15:0] r_pr;

    logic        w_accept;
    logic [15:0] w_amag;
    logic [16:0] w_bmag;
    logic [16:0] w_shift;
    logic        w_ge;
    logic [15:0] w_diff;
    logic        w_dz;
    logic        w_ofs;

    assign w_accept = ((r_state == c_IDLE) || (r_state == c_DONE)) && Start;

    // Magnitude of 0x8000 is 0x8000; the divisor path is carried at 17 bits
    assign w_amag = (Signed && A[15]) ? (~A + 16'd1) : A;
    assign w_bmag = {1'b0, ((Signed && B[15]) ? (~B + 16'd1) : B)};

    assign w_shift = {r_pr, r_q[15]};
    assign w_ge    = (w_shift >= r_bmag);
    assign w_diff  = 16'(w_shift - r_bmag);

    assign w_dz  = (r_b == 16'h0000);
    assign w_ofs = r_sgn && (r_a == 16'h8000) && (r_b == 16'hFFFF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  w_next = Start ? c_CALC : c_IDLE;
            c_CALC:  w_next = (r_cnt == 4'd15) ? c_FIX : c_CALC;
            c_FIX:   w_next = r_fix ? c_DONE : c_FIX;
            c_DONE:  w_next = Start ? c_CALC : c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    always_comb begin
        Busy = (r_state == c_CALC) || (r_state == c_FIX);
        Done = (r_state == c_DONE);
    end

    // FIX spans two cycles: sign correction, then publishing the results,
    // which keeps the accept-to-Done distance at 18 edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= 4'd0;
            r_fix   <= 1'b0;
            r_sgn   <= 1'b0;
            r_a     <= 16'h0000;
            r_b     <= 16'h0000;
            r_bmag  <= 17'h00000;
            r_q     <= 16'h0000;
            r_pr    <= 16'h0000;
            Quot    <= 16'h0000;
            Rem     <= 16'h0000;
            DivZero <= 1'b0;
            OFs     <= 1'b0;
        end else if (w_accept) begin
            r_a    <= A;
            r_b    <= B;
            r_sgn  <= Signed;
            r_bmag <= w_bmag;
            r_q    <= w_amag;
            r_pr   <= 16'h0000;
            r_cnt  <= 4'd0;
            r_fix  <= 1'b0;
        end else if (r_state == c_CALC) begin
            r_cnt <= r_cnt + 4'd1;
            if (w_ge) begin
                r_pr <= w_diff;
                r_q  <= {r_q[14:0], 1'b1};
            end else begin
                r_pr <= w_shift[15:0];
                r_q  <= {r_q[14:0], 1'b0};
            end
        end else if (r_state == c_FIX) begin
            if (!r_fix) begin
                r_fix <= 1'b1;
                if (r_sgn && (r_a[15] ^ r_b[15])) begin
                    r_q <= ~r_q + 16'd1;
                end
                if (r_sgn && r_a[15]) begin
                    r_pr <= ~r_pr + 16'd1;
                end
            end else begin
                Quot    <= w_dz ? 16'hFFFF : r_q;
                Rem     <= w_dz ? r_a : r_pr;
                DivZero <= w_dz;
                OFs     <= w_ofs;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div16_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_div16_seq
// Brief   : Self-checking bench for div16_seq with an arithmetic reference model
// Revision: 1.0
// ============================================================================
module tb_div16_seq;

    logic        clk;
    logic        rst;
    logic        Start;
    logic        Signed;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] Quot;
    logic [15:0] Rem;
    logic        Busy;
    logic        Done;
    logic        DivZero;
    logic        OFs;

    int n_checks = 0;
    int n_pass   = 0;

    div16_seq dut (
        .clk     (clk),
        .rst     (rst),
        .Start   (Start),
        .Signed  (Signed),
        .A       (A),
        .B       (B),
        .Quot    (Quot),
        .Rem     (Rem),
        .Busy    (Busy),
        .Done    (Done),
        .DivZero (DivZero),
        .OFs     (OFs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h required %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference division from plain arithmetic: {quot, rem, divzero, ofs}
    function automatic logic [33:0] ref_div(input logic [15:0] a, input logic [15:0] b, input logic s);
        int sa;
        int sb;
        int q;
        int r;
        if (b == 16'h0000) return {16'hFFFF, a, 1'b1, 1'b0};
        if (!s) return {16'(a / b), 16'(a % b), 2'b00};
        if (a == 16'h8000 && b == 16'hFFFF) return {16'h8000, 16'h0000, 2'b01};
        sa = int'($signed(a));
        sb = int'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {q[15:0], r[15:0], 2'b00};
    endfunction

    // Transaction-level model: an accepted request completes 18 edges later
    int          m_cnt;
    logic        m_done;
    logic [15:0] m_q;
    logic [15:0] m_r;
    logic        m_dz;
    logic        m_of;
    logic [33:0] m_pend;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt  <= 0;
            m_done <= 1'b0;
            m_q    <= 16'h0000;
            m_r    <= 16'h0000;
            m_dz   <= 1'b0;
            m_of   <= 1'b0;
            m_pend <= '0;
        end else if (m_cnt == 0) begin
            m_done <= 1'b0;
            if (Start) begin
                m_cnt  <= 18;
                m_pend <= ref_div(A, B, Signed);
            end
        end else begin
            m_cnt  <= m_cnt - 1;
            m_done <= (m_cnt == 1);
            if (m_cnt == 1) begin
                {m_q, m_r, m_dz, m_of} <= m_pend;
            end
        end
    end

    always @(negedge clk) begin
        check("busy",    32'(Busy),    32'(m_cnt != 0));
        check("done",    32'(Done),    32'(m_done));
        check("quot",    32'(Quot),    32'(m_q));
        check("rem",     32'(Rem),     32'(m_r));
        check("divzero", 32'(DivZero), 32'(m_dz));
        check("ofs",     32'(OFs),     32'(m_of));
    end

    // Caller is at a falling edge; returns at the falling edge where Done is seen
    task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic s, output int lat);
        int k;
        Start  = 1'b1;
        A      = a;
        B      = b;
        Signed = s;
        @(negedge clk);
        Start  = 1'b0;
        A      = 16'($urandom);
        B      = 16'($urandom);
        Signed = 1'($urandom);
        k = 1;
        while (!Done && k < 40) begin
            @(negedge clk);
            k++;
        end
        lat = k - 1;
    endtask

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic s, output int lat);
        @(negedge clk);
        launch(a, b, s, lat);
    endtask

    task automatic expect_res(input string name, input int lat, input logic [15:0] q,
                              input logic [15:0] r, input logic dz, input logic of);
        check({name, "_lat"},  32'(lat),     32'd18);
        check({name, "_quot"}, 32'(Quot),    32'(q));
        check({name, "_rem"},  32'(Rem),     32'(r));
        check({name, "_dz"},   32'(DivZero), 32'(dz));
        check({name, "_ofs"},  32'(OFs),     32'(of));
    endtask

    function automatic logic [15:0] pick_a();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'h7FFF;
            2:       return 16'h8000;
            3:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [15:0] pick_b();
        case ($urandom_range(0, 7))
            0:       return 16'h0000;
            1:       return 16'h0001;
            2:       return 16'hFFFF;
            3:       return 16'($urandom_range(1, 20));
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int lat;
        int k;
        rst    = 1'b1;
        Start  = 1'b0;
        Signed = 1'b0;
        A      = 16'h0000;
        B      = 16'h0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_quot", 32'(Quot), 32'd0);
        check("rst_rem",  32'(Rem),  32'd0);
        check("rst_dz",   32'(DivZero), 32'd0);
        check("rst_ofs",  32'(OFs),  32'd0);

        do_op(16'd100, 16'd7, 1'b0, lat);
        expect_res("u100_7", lat, 16'd14, 16'd2, 1'b0, 1'b0);
        do_op(16'hFFF9, 16'h0002, 1'b1, lat);
        expect_res("s_m7_2", lat, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0);
        do_op(16'h0007, 16'hFFFE, 1'b1, lat);
        expect_res("s_7_m2", lat, 16'hFFFD, 16'h0001, 1'b0, 1'b0);
        do_op(16'h1234, 16'h0000, 1'b0, lat);
        expect_res("dz_u", lat, 16'hFFFF, 16'h1234, 1'b1, 1'b0);
        do_op(16'h1234, 16'h0000, 1'b1, lat);
        expect_res("dz_s", lat, 16'hFFFF, 16'h1234, 1'b1, 1'b0);
        do_op(16'h8000, 16'hFFFF, 1'b1, lat);
        expect_res("ovf_s", lat, 16'h8000, 16'h0000, 1'b0, 1'b1);
        do_op(16'h8000, 16'hFFFF, 1'b0, lat);
        expect_res("ovf_u", lat, 16'h0000, 16'h8000, 1'b0, 1'b0);

        // Start while busy must be ignored
        @(negedge clk);
        Start = 1'b1; A = 16'd100; B = 16'd7; Signed = 1'b0;
        @(negedge clk);
        Start = 1'b0;
        k = 1;
        while (k < 5) begin @(negedge clk); k++; end
        Start = 1'b1; A = 16'd5; B = 16'd1; Signed = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        k++;
        while (!Done && k < 40) begin @(negedge clk); k++; end
        expect_res("ignored", k - 1, 16'd14, 16'd2, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("ignored_no_extra_done", 32'(Done), 32'd0);
        end

        // Back-to-back: new Start during the DONE cycle
        do_op(16'd1000, 16'd10, 1'b0, lat);
        expect_res("b2b_1", lat, 16'd100, 16'd0, 1'b0, 1'b0);
        launch(16'hFF38, 16'd7, 1'b1, lat);
        expect_res("b2b_2", lat, 16'hFFE4, 16'hFFFC, 1'b0, 1'b0);

        // Reset in the middle of an operation
        @(negedge clk);
        Start = 1'b1; A = 16'd500; B = 16'd3; Signed = 1'b0;
        @(negedge clk);
        Start = 1'b0;
        k = 1;
        while (k < 8) begin @(negedge clk); k++; end
        #2 rst = 1'b1;
        Start = 1'b1;
        #1;
        check("midrst_busy", 32'(Busy), 32'd0);
        check("midrst_done", 32'(Done), 32'd0);
        check("midrst_quot", 32'(Quot), 32'd0);
        check("midrst_rem",  32'(Rem),  32'd0);
        repeat (2) @(negedge clk);
        Start = 1'b0;
        #2 rst = 1'b0;
        repeat (25) begin
            @(negedge clk);
            check("midrst_no_done", 32'(Done), 32'd0);
        end
        do_op(16'hFFFF, 16'h0010, 1'b0, lat);
        expect_res("after_rst", lat, 16'h0FFF, 16'h000F, 1'b0, 1'b0);

        // Randomized operands per mode, checked every cycle by the model
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 1800; i++) begin
                do_op(pick_a(), pick_b(), 1'(m), lat);
                check("rand_lat", 32'(lat), 32'd18);
            end
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
